// File: rtl/block_pe_param.sv
// Parametrised CGRA processing element: registered ALU with accumulate, scratchpad, double-buffered serial config chain.
// Optional feature macro: PE_MUL_EN enables the single-cycle multiplier for opcode 5 (otherwise opcode 5 yields 0).
module block_pe_param #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 2,
    parameter int MEM_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    config_en,
    input  logic                    config_in,
    output logic                    config_out,
    input  logic                    config_load,
    input  logic                    in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out0
);

    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int SEL_W = $clog2(NUM_IN + 2);
    localparam int CFG_W = 4 * SEL_W + 5;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_ACC  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] mem_q, mem_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] scratch [MEM_DEPTH];

    logic [SEL_W-1:0] alu_sel0, alu_sel1, mem_sel0, mem_sel1;
    logic [2:0]       alu_op;
    logic             mem_wr, out_sel;
    logic [WIDTH-1:0] op0, op1, m0, m1, alu_res;
    logic [AW-1:0]    mem_addr;

    // Operand source: input ports, then the two registered feedback paths, anything else reads as zero.
    function automatic logic [WIDTH-1:0] pick(input logic [SEL_W-1:0] sel,
                                              input logic [NUM_IN*WIDTH-1:0] ins,
                                              input logic [WIDTH-1:0] fb_alu,
                                              input logic [WIDTH-1:0] fb_mem);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) r = ins[k*WIDTH +: WIDTH];
        end
        if (sel == SEL_W'(NUM_IN))     r = fb_alu;
        if (sel == SEL_W'(NUM_IN + 1)) r = fb_mem;
        return r;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [WIDTH-1:0] w);
        return w[AW-1:0];
    endfunction

    assign alu_sel0 = active_q[CFG_W-1           -: SEL_W];
    assign alu_sel1 = active_q[CFG_W-1-SEL_W     -: SEL_W];
    assign mem_sel0 = active_q[CFG_W-1-2*SEL_W   -: SEL_W];
    assign mem_sel1 = active_q[CFG_W-1-3*SEL_W   -: SEL_W];
    assign alu_op   = active_q[4:2];
    assign mem_wr   = active_q[1];
    assign out_sel  = active_q[0];

    always_comb begin
        op0      = pick(alu_sel0, in_data, alu_q, mem_q);
        op1      = pick(alu_sel1, in_data, alu_q, mem_q);
        m0       = pick(mem_sel0, in_data, alu_q, mem_q);
        m1       = pick(mem_sel1, in_data, alu_q, mem_q);
        mem_addr = addr_of(m0);
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = op0 + op1;
            OP_SUB:  alu_res = op0 - op1;
            OP_AND:  alu_res = op0 & op1;
            OP_OR:   alu_res = op0 | op1;
            OP_XOR:  alu_res = op0 ^ op1;
`ifdef PE_MUL_EN
            OP_MUL:  alu_res = op0 * op1;
`else
            OP_MUL:  alu_res = '0;
`endif
            OP_ACC:  alu_res = acc_q + op0;
            OP_PASS: alu_res = op0;
            default: alu_res = '0;
        endcase
    end

    // A load clears the accumulator even when a valid operand arrives in the same cycle.
    always_comb begin
        shadow_d    = config_en ? {shadow_q[CFG_W-2:0], config_in} : shadow_q;
        active_d    = config_load ? shadow_q : active_q;
        out_valid_d = in_valid;
        alu_d       = in_valid ? alu_res : alu_q;
        mem_d       = in_valid ? scratch[mem_addr] : mem_q;
        acc_d       = acc_q;
        if (config_load)
            acc_d = '0;
        else if (in_valid && alu_op == OP_ACC)
            acc_d = alu_res;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            active_q    <= '0;
            acc_q       <= '0;
            alu_q       <= '0;
            mem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            acc_q       <= acc_d;
            alu_q       <= alu_d;
            mem_q       <= mem_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Scratchpad contents survive reset.
    always_ff @(posedge clk) begin
        if (in_valid && mem_wr)
            scratch[mem_addr] <= m1;
    end

    assign config_out = shadow_q[CFG_W-1];
    assign out_valid  = out_valid_q;
    assign out0       = out_sel ? mem_q : alu_q;

endmodule

// File: tb/tb_block_pe_param.sv
// Directed self-checking bench for block_pe_param: two chained blocks at default parameters.
module tb_block_pe_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        configEn, configIn, configLoad, inValid;
    logic [63:0] inData;
    logic        chainMid, chainEnd;
    logic        outValid, outValid2;
    logic [31:0] out0, out0b;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    block_pe_param dut (
        .clk(clk), .reset(reset), .config_en(configEn), .config_in(configIn),
        .config_out(chainMid), .config_load(configLoad), .in_valid(inValid),
        .in_data(inData), .out_valid(outValid), .out0(out0)
    );

    block_pe_param dut2 (
        .clk(clk), .reset(reset), .config_en(configEn), .config_in(chainMid),
        .config_out(chainEnd), .config_load(configLoad), .in_valid(inValid),
        .in_data(inData), .out_valid(outValid2), .out0(out0b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] mkCfg(input int s0, input int s1, input int m0, input int m1,
                                          input int op, input int wr, input int os);
        return {2'(s0), 2'(s1), 2'(m0), 2'(m1), 3'(op), 1'(wr), 1'(os)};
    endfunction

    task automatic shiftConfig(input logic [12:0] w);
        for (int i = 12; i >= 0; i--) begin
            configEn = 1'b1;
            configIn = w[i];
            tick();
        end
        configEn = 1'b0;
        configIn = 1'b0;
    endtask

    task automatic loadConfig();
        configLoad = 1'b1;
        tick();
        configLoad = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        inData  = {b, a};
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; configEn = 0; configIn = 0; configLoad = 0; inValid = 0; inData = '0;
        tick();
        checkOutput("reset out0", out0, 32'd0);
        checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset config_out", {31'd0, chainMid}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("idle out_valid", {31'd0, outValid}, 32'd0);
        end

        applyStimulus(32'd5, 32'd99);
        checkOutput("default cfg port0+port0", out0, 32'd10);

        shiftConfig(mkCfg(0, 1, 0, 0, 0, 0, 0));
        loadConfig();
        applyStimulus(32'd5, 32'd7);
        checkOutput("add 5+7", out0, 32'd12);
        checkOutput("add out_valid", {31'd0, outValid}, 32'd1);
        applyStimulus(32'hFFFF_FFFF, 32'd2);
        checkOutput("add wrap", out0, 32'd1);
        tick();
        checkOutput("out_valid drops", {31'd0, outValid}, 32'd0);
        checkOutput("out0 holds", out0, 32'd1);

        shiftConfig(mkCfg(0, 1, 0, 0, 1, 0, 0));
        loadConfig();
        applyStimulus(32'd3, 32'd5);
        checkOutput("sub wrap", out0, 32'hFFFF_FFFE);
        shiftConfig(mkCfg(0, 1, 0, 0, 2, 0, 0));
        loadConfig();
        applyStimulus(32'hF0F0, 32'hFF00);
        checkOutput("and", out0, 32'hF000);
        shiftConfig(mkCfg(0, 1, 0, 0, 4, 0, 0));
        loadConfig();
        applyStimulus(32'hF0F0, 32'hFF00);
        checkOutput("xor", out0, 32'h0FF0);
        shiftConfig(mkCfg(0, 1, 0, 0, 7, 0, 0));
        loadConfig();
        applyStimulus(32'h1234, 32'h5678);
        checkOutput("pass", out0, 32'h1234);

        shiftConfig(mkCfg(0, 0, 0, 0, 6, 0, 0));
        loadConfig();
        applyStimulus(32'd3, 32'd0);
        checkOutput("acc 1st", out0, 32'd3);
        applyStimulus(32'd4, 32'd0);
        checkOutput("acc 2nd", out0, 32'd7);
        applyStimulus(32'd10, 32'd0);
        checkOutput("acc 3rd", out0, 32'd17);
        loadConfig();
        applyStimulus(32'd1, 32'd0);
        checkOutput("acc after reload", out0, 32'd1);

        shiftConfig(mkCfg(0, 0, 0, 1, 0, 1, 1));
        loadConfig();
        applyStimulus(32'd2, 32'h55);
        applyStimulus(32'd18, 32'hAB);
        checkOutput("mem write wrap reads old", out0, 32'h55);
        shiftConfig(mkCfg(0, 0, 0, 1, 0, 0, 1));
        loadConfig();
        applyStimulus(32'd2, 32'd0);
        checkOutput("mem read addr2", out0, 32'hAB);
        applyStimulus(32'd18, 32'd0);
        checkOutput("mem read addr18", out0, 32'hAB);

        inData  = {32'd1, 32'd2};
        inValid = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midcycle reset out0", out0, 32'd0);
        checkOutput("midcycle reset out_valid", {31'd0, outValid}, 32'd0);
        inValid = 1'b0;
        tick();
        checkOutput("in-flight dropped", {31'd0, outValid}, 32'd0);
        reset = 1'b0;

        shiftConfig(mkCfg(2, 0, 0, 0, 0, 0, 0));
        checkOutput("config_out msb", {31'd0, chainMid}, 32'd1);
        loadConfig();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(32'd1, 32'd0);
            checkOutput("feedback", out0, 32'(i));
        end

        shiftConfig(mkCfg(0, 1, 0, 0, 5, 0, 0));
        loadConfig();
        applyStimulus(32'd6, 32'd7);
`ifdef PE_MUL_EN
        checkOutput("mul 6x7", out0, 32'd42);
`else
        checkOutput("mul 6x7 disabled", out0, 32'd0);
`endif
        checkOutput("mul out_valid", {31'd0, outValid}, 32'd1);

        shiftConfig(mkCfg(0, 1, 0, 0, 1, 0, 0));
        shiftConfig(mkCfg(0, 1, 0, 0, 0, 0, 0));
        loadConfig();
        applyStimulus(32'd9, 32'd4);
        checkOutput("chain block1 add", out0, 32'd13);
        checkOutput("chain block2 sub", out0b, 32'd5);
        checkOutput("chain block2 valid", {31'd0, outValid2}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
